cpu_execution_unit: RTL and testbench

//  Multicycle RV32-style datapath of the CPU: PC, instruction register, 32x32 register file,

---
 rtl/cpu_pkg.sv | 28 ++
 rtl/cpu_alu.sv | 22 ++
 rtl/cpu_execution_unit.sv | 120 ++++++++++++
 tb/tb_cpu_execution_unit.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared encodings for the multicycle CPU execution unit datapath
package cpu_pkg;

  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_SUB = 2'b01,
    ALU_AND = 2'b10,
    ALU_OR  = 2'b11
  } alu_op_e;

  localparam logic       SRCA_RS1  = 1'b0;
  localparam logic       SRCA_PC   = 1'b1;

  localparam logic [1:0] SRCB_RS2  = 2'd0;
  localparam logic [1:0] SRCB_ONE  = 2'd1;
  localparam logic [1:0] SRCB_IMM  = 2'd2;
  localparam logic [1:0] SRCB_ZERO = 2'd3;

  localparam logic       IDRAM_SEL_ADDR_I = 1'b1;
  localparam logic       IDRAM_SEL_ADDR_D = 1'b0;

  localparam logic [2:0] INST_TYPE_B = 3'd0;
  localparam logic [2:0] INST_TYPE_S = 3'd1;
  localparam logic [2:0] INST_TYPE_I = 3'd2;
  localparam logic [2:0] INST_TYPE_J = 3'd3;
  localparam logic [2:0] INST_TYPE_U = 3'd4;

endpackage

// File: rtl/cpu_alu.sv
// rtl/cpu_alu.sv - 32-bit four-operation ALU, wrap-around arithmetic, no flags
module cpu_alu
  import cpu_pkg::*;
(
  input  logic [1:0]  op_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic [31:0] result_o
);

  always_comb begin
    result_o = '0;
    case (alu_op_e'(op_i))
      ALU_ADD: result_o = a_i + b_i;
      ALU_SUB: result_o = a_i - b_i;
      ALU_AND: result_o = a_i & b_i;
      ALU_OR:  result_o = a_i | b_i;
      default: result_o = '0;
    endcase
  end

endmodule

// File: rtl/cpu_execution_unit.sv
// rtl/cpu_execution_unit.sv - multicycle datapath: PC, IR, register file, unified IDRam, immediates, ALU
module cpu_execution_unit
  import cpu_pkg::*;
#(
  parameter int    MEM_DEPTH     = 256,
  parameter string MEM_INIT_FILE = ""
) (
  input  logic        r_Clk,
  input  logic        r_Rst,
  input  logic        i_PCWrite,
  input  logic        r_IRegWrite,
  output logic [31:0] o_Instruction,
  input  logic        i_REGWriteEn,
  input  logic        i_IDAddrSel,
  input  logic        i_IDMemWrite,
  input  logic [2:0]  i_InstType,
  input  logic [1:0]  i_ALUOpCode,
  input  logic        i_ALUSrcASel,
  input  logic [1:0]  i_ALUSrcBSel
);

  localparam int AW = $clog2(MEM_DEPTH);

  logic [31:0] pc_q, pc_d;
  logic [31:0] ir_q, ir_d;
  logic [31:0] alu_out_q, alu_out_d;
  logic [31:0] regs_q [32];
  logic [31:0] mem_q  [MEM_DEPTH];

  logic [4:0]    rs1, rs2, rd;
  logic [31:0]   rs1_val, rs2_val;
  logic [31:0]   imm;
  logic [31:0]   alu_a, alu_b, alu_result;
  logic [31:0]   mem_addr_full;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_rdata;
  logic          unused_addr_bits;

  // Memory image is a power-on preload only; reset never touches it.
  initial begin
    for (int i = 0; i < MEM_DEPTH; i++) mem_q[i] = '0;
  end

  assign rs1 = ir_q[19:15];
  assign rs2 = ir_q[24:20];
  assign rd  = ir_q[11:7];

  assign rs1_val = (rs1 == 5'd0) ? '0 : regs_q[rs1];
  assign rs2_val = (rs2 == 5'd0) ? '0 : regs_q[rs2];

  assign mem_addr_full    = (i_IDAddrSel == IDRAM_SEL_ADDR_I) ? pc_q : alu_out_q;
  assign mem_addr         = mem_addr_full[AW-1:0];
  assign unused_addr_bits = ^mem_addr_full[31:AW];
  assign mem_rdata        = mem_q[mem_addr];

  always_comb begin
    imm = '0;
    case (i_InstType)
      INST_TYPE_I: imm = {{20{ir_q[31]}}, ir_q[31:20]};
      INST_TYPE_S: imm = {{20{ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
      INST_TYPE_B: imm = {{19{ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};
      INST_TYPE_J: imm = {{11{ir_q[31]}}, ir_q[31], ir_q[19:12], ir_q[20], ir_q[30:21], 1'b0};
      INST_TYPE_U: imm = {ir_q[31:12], 12'b0};
      default:     imm = '0;
    endcase
  end

  always_comb begin
    alu_a = (i_ALUSrcASel == SRCA_PC) ? pc_q : rs1_val;
    alu_b = '0;
    case (i_ALUSrcBSel)
      SRCB_RS2:  alu_b = rs2_val;
      SRCB_ONE:  alu_b = 32'd1;
      SRCB_IMM:  alu_b = imm;
      SRCB_ZERO: alu_b = '0;
      default:   alu_b = '0;
    endcase
  end

  cpu_alu u_alu (
    .op_i     (i_ALUOpCode),
    .a_i      (alu_a),
    .b_i      (alu_b),
    .result_o (alu_result)
  );

  always_comb begin
    pc_d      = i_PCWrite   ? alu_result : pc_q;
    ir_d      = r_IRegWrite ? mem_rdata  : ir_q;
    alu_out_d = alu_result;
  end

  always_ff @(posedge r_Clk or negedge r_Rst) begin
    if (!r_Rst) begin
      pc_q      <= '0;
      ir_q      <= '0;
      alu_out_q <= '0;
    end else begin
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      alu_out_q <= alu_out_d;
    end
  end

  // Load data comes straight from the asynchronous RAM read in the same cycle.
  always_ff @(posedge r_Clk or negedge r_Rst) begin
    if (!r_Rst) begin
      for (int i = 0; i < 32; i++) regs_q[i] <= '0;
    end else if (i_REGWriteEn && (rd != 5'd0)) begin
      regs_q[rd] <= mem_rdata;
    end
  end

  always_ff @(posedge r_Clk) begin
    if (i_IDMemWrite) mem_q[mem_addr] <= rs2_val;
  end

  assign o_Instruction = ir_q;

endmodule

// File: tb/tb_cpu_execution_unit.sv
// tb/tb_cpu_execution_unit.sv - self-checking bench for cpu_execution_unit against a behavioural model
module tb_cpu_execution_unit;

  logic        r_Clk = 1'b0;
  logic        r_Rst = 1'b0;
  logic        i_PCWrite = 1'b0, r_IRegWrite = 1'b0, i_REGWriteEn = 1'b0;
  logic        i_IDAddrSel = 1'b0, i_IDMemWrite = 1'b0, i_ALUSrcASel = 1'b0;
  logic [2:0]  i_InstType = 3'd0;
  logic [1:0]  i_ALUOpCode = 2'd0, i_ALUSrcBSel = 2'd0;
  logic [31:0] o_Instruction;

  int errors = 0;
  int checks = 0;

  logic [31:0] m_mem  [256];
  logic [31:0] m_regs [32];
  logic [31:0] m_pc, m_ir, m_alu_out;

  cpu_execution_unit #(.MEM_DEPTH(256), .MEM_INIT_FILE("")) dut (
    .r_Clk         (r_Clk),
    .r_Rst         (r_Rst),
    .i_PCWrite     (i_PCWrite),
    .r_IRegWrite   (r_IRegWrite),
    .o_Instruction (o_Instruction),
    .i_REGWriteEn  (i_REGWriteEn),
    .i_IDAddrSel   (i_IDAddrSel),
    .i_IDMemWrite  (i_IDMemWrite),
    .i_InstType    (i_InstType),
    .i_ALUOpCode   (i_ALUOpCode),
    .i_ALUSrcASel  (i_ALUSrcASel),
    .i_ALUSrcBSel  (i_ALUSrcBSel)
  );

  always #5 r_Clk = ~r_Clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] reg_read(input logic [4:0] idx);
    return (idx == 5'd0) ? 32'd0 : m_regs[idx];
  endfunction

  // Immediate built arithmetically: sign from an arithmetic shift, fields OR'd into place.
  function automatic logic [31:0] ref_imm(input logic [31:0] ir, input logic [2:0] t);
    logic signed [31:0] s;
    s = ir;
    case (t)
      3'd0: return 32'(s >>> 31) << 12 | 32'(ir[7]) << 11 | 32'(ir[30:25]) << 5 | 32'(ir[11:8]) << 1;
      3'd1: return 32'(s >>> 25) << 5 | 32'(ir[11:7]);
      3'd2: return 32'(s >>> 20);
      3'd3: return 32'(s >>> 31) << 20 | 32'(ir[19:12]) << 12 | 32'(ir[20]) << 11 | 32'(ir[30:21]) << 1;
      3'd4: return ir & 32'hFFFF_F000;
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_reset();
    m_pc = 0; m_ir = 0; m_alu_out = 0;
    for (int i = 0; i < 32; i++) m_regs[i] = 0;
  endtask

  task automatic poke(input logic [7:0] a, input logic [31:0] v);
    m_mem[a] = v;
    dut.mem_q[a] <= v;
    #1;
  endtask

  task automatic cycle(input logic pcw, input logic irw, input logic regwe, input logic addrsel,
                       input logic memw, input logic srca, input logic [1:0] srcb,
                       input logic [1:0] op, input logic [2:0] itype);
    logic [31:0] a, b, res, rdata, rs2v;
    logic [7:0]  addr;
    logic [4:0]  rd;
    a = srca ? m_pc : reg_read(m_ir[19:15]);
    case (srcb)
      2'd0:    b = reg_read(m_ir[24:20]);
      2'd1:    b = 32'd1;
      2'd2:    b = ref_imm(m_ir, itype);
      default: b = 32'd0;
    endcase
    case (op)
      2'd0:    res = a + b;
      2'd1:    res = a - b;
      2'd2:    res = a & b;
      default: res = a | b;
    endcase
    addr  = addrsel ? m_pc[7:0] : m_alu_out[7:0];
    rdata = m_mem[addr];
    rs2v  = reg_read(m_ir[24:20]);
    rd    = m_ir[11:7];
    i_PCWrite = pcw; r_IRegWrite = irw; i_REGWriteEn = regwe; i_IDAddrSel = addrsel;
    i_IDMemWrite = memw; i_ALUSrcASel = srca; i_ALUSrcBSel = srcb; i_ALUOpCode = op;
    i_InstType = itype;
    @(posedge r_Clk);
    #1;
    m_alu_out = res;
    if (pcw) m_pc = res;
    if (irw) m_ir = rdata;
    if (regwe && rd != 0) m_regs[rd] = rdata;
    if (memw) m_mem[addr] = rs2v;
    i_PCWrite = 0; r_IRegWrite = 0; i_REGWriteEn = 0; i_IDMemWrite = 0;
  endtask

  task automatic fetch();
    cycle(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 2'd1, 2'd0, 3'd0);
  endtask

  task automatic set_ir(input logic [31:0] v);
    poke(m_pc[7:0], v);
    fetch();
  endtask

  task automatic load_reg(input logic [4:0] rd, input logic [31:0] v);
    logic [11:0] a;
    a = 12'd200 + 12'(rd);
    poke(a[7:0], v);
    set_ir({a, 5'd0, 3'b010, rd, 7'h03});
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 2'd0, 3'd2);
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd2, 2'd0, 3'd2);
  endtask

  task automatic test_reset();
    int bad;
    r_Rst = 1'b0;
    repeat (3) @(posedge r_Clk);
    #1;
    model_reset();
    checks++;
    if (o_Instruction !== 32'd0) begin
      errors++; $display("FAIL reset_ir: got %h want 00000000", o_Instruction);
    end
    checks++;
    if (dut.pc_q !== 32'd0) begin
      errors++; $display("FAIL reset_pc: got %h want 00000000", dut.pc_q);
    end
    checks++;
    if (dut.alu_out_q !== 32'd0) begin
      errors++; $display("FAIL reset_aluout: got %h want 00000000", dut.alu_out_q);
    end
    bad = 0;
    for (int i = 0; i < 32; i++) if (dut.regs_q[i] !== 32'd0) bad++;
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL reset_regs: %0d nonzero registers, want 0", bad);
    end
    r_Rst = 1'b1;
  endtask

  task automatic test_fetch();
    poke(8'd0, 32'h0040_2083);
    fetch();
    checks++;
    if (o_Instruction !== 32'h0040_2083) begin
      errors++; $display("FAIL fetch_ir: got %h want 00402083", o_Instruction);
    end
    checks++;
    if (dut.pc_q !== 32'd1) begin
      errors++; $display("FAIL fetch_pc: got %h want 00000001", dut.pc_q);
    end
  endtask

  task automatic test_load();
    poke(8'd4, 32'hDEAD_BEEF);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 2'd0, 3'd2);
    checks++;
    if (dut.alu_out_q !== 32'd4) begin
      errors++; $display("FAIL load_addr: got %h want 00000004", dut.alu_out_q);
    end
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd2, 2'd0, 3'd2);
    checks++;
    if (dut.regs_q[1] !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL load_x1: got %h want deadbeef", dut.regs_q[1]);
    end
    checks++;
    if (dut.alu_out_q !== 32'd4) begin
      errors++; $display("FAIL load_aluout: got %h want 00000004", dut.alu_out_q);
    end
  endtask

  task automatic test_store();
    load_reg(5'd1, 32'd5);
    load_reg(5'd2, 32'h1234_5678);
    poke(8'd5, 32'hA5A5_0F0F);
    set_ir(32'h0020_A023);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 2'd0, 3'd1);
    checks++;
    if (dut.alu_out_q !== 32'd5) begin
      errors++; $display("FAIL store_addr: got %h want 00000005", dut.alu_out_q);
    end
    // IR reads the same word being written: must see the old contents
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'd2, 2'd0, 3'd1);
    checks++;
    if (dut.mem_q[5] !== 32'h1234_5678) begin
      errors++; $display("FAIL store_mem5: got %h want 12345678", dut.mem_q[5]);
    end
    checks++;
    if (o_Instruction !== 32'hA5A5_0F0F) begin
      errors++; $display("FAIL store_read_old: got %h want a5a50f0f", o_Instruction);
    end
  endtask

  task automatic test_alu_ops();
    logic [31:0] want [4];
    want[0] = 32'h0000_004B; want[1] = 32'hFFFF_FFD3; want[2] = 32'h0000_000C; want[3] = 32'h0000_003F;
    load_reg(5'd1, 32'h0F);
    load_reg(5'd2, 32'h3C);
    set_ir({7'b0, 5'd2, 5'd1, 3'b000, 5'd0, 7'h33});
    for (int op = 0; op < 4; op++) begin
      cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'(op), 3'd0);
      checks++;
      if (dut.alu_out_q !== want[op]) begin
        errors++; $display("FAIL alu_op%0d: got %h want %h", op, dut.alu_out_q, want[op]);
      end
    end
    poke(m_pc[7:0], 32'hCAFE_F00D);
    cycle(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd3, 2'd0, 3'd0);
    checks++;
    if (dut.regs_q[0] !== 32'd0) begin
      errors++; $display("FAIL x0_write: got %h want 00000000", dut.regs_q[0]);
    end
  endtask

  task automatic test_random_alu();
    logic [31:0] a, b;
    logic [4:0]  ra, rb, rd;
    logic [1:0]  op, srcb;
    logic        srca;
    for (int it = 0; it < 12; it++) begin
      a  = $urandom; b = $urandom;
      op = 2'($urandom_range(0, 3));
      ra = 5'($urandom_range(1, 31));
      rb = 5'($urandom_range(1, 30));
      if (rb >= ra) rb = rb + 5'd1;
      rd = 5'($urandom_range(1, 31));
      srca = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 2))
        0:       srcb = 2'd0;
        1:       srcb = 2'd1;
        default: srcb = 2'd3;
      endcase
      load_reg(ra, a);
      load_reg(rb, b);
      set_ir({7'b0, rb, ra, 3'b000, rd, 7'h33});
      cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, srca, srcb, op, 3'd0);
      checks++;
      if (dut.alu_out_q !== m_alu_out) begin
        errors++; $display("FAIL rand_alu%0d: got %h want %h", it, dut.alu_out_q, m_alu_out);
      end
      poke(m_pc[7:0], $urandom);
      cycle(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 3'd0);
      checks++;
      if (dut.regs_q[rd] !== m_regs[rd]) begin
        errors++; $display("FAIL rand_regwr%0d: got %h want %h", it, dut.regs_q[rd], m_regs[rd]);
      end
      checks++;
      if (dut.pc_q !== m_pc) begin
        errors++; $display("FAIL rand_pc%0d: got %h want %h", it, dut.pc_q, m_pc);
      end
    end
  endtask

  task automatic test_immediates();
    logic [31:0] ir;
    set_ir(32'hFFF0_0093);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 2'd0, 3'd2);
    checks++;
    if (dut.alu_out_q !== 32'hFFFF_FFFF) begin
      errors++; $display("FAIL imm_i: got %h want ffffffff", dut.alu_out_q);
    end
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 2'd0, 3'd4);
    checks++;
    if (dut.alu_out_q !== 32'hFFF0_0000) begin
      errors++; $display("FAIL imm_u: got %h want fff00000", dut.alu_out_q);
    end
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 2'd0, 3'd5);
    checks++;
    if (dut.alu_out_q !== 32'd0) begin
      errors++; $display("FAIL imm_type5: got %h want 00000000", dut.alu_out_q);
    end
    for (int it = 0; it < 6; it++) begin
      ir = $urandom & ~(32'h1F << 15);
      set_ir(ir);
      for (int t = 0; t < 8; t++) begin
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 2'd0, 3'(t));
        checks++;
        if (dut.alu_out_q !== ref_imm(ir, 3'(t))) begin
          errors++; $display("FAIL rand_imm ir=%h type=%0d: got %h want %h",
                             ir, t, dut.alu_out_q, ref_imm(ir, 3'(t)));
        end
      end
    end
  endtask

  task automatic test_async_reset();
    poke(m_pc[7:0], 32'h1357_9BDF);
    fetch();
    @(negedge r_Clk);
    r_Rst = 1'b0;
    #1;
    checks++;
    if (dut.pc_q !== 32'd0) begin
      errors++; $display("FAIL async_pc: got %h want 00000000", dut.pc_q);
    end
    checks++;
    if (o_Instruction !== 32'd0) begin
      errors++; $display("FAIL async_ir: got %h want 00000000", o_Instruction);
    end
    checks++;
    if (dut.alu_out_q !== 32'd0) begin
      errors++; $display("FAIL async_aluout: got %h want 00000000", dut.alu_out_q);
    end
    checks++;
    if (dut.regs_q[1] !== 32'd0) begin
      errors++; $display("FAIL async_x1: got %h want 00000000", dut.regs_q[1]);
    end
    @(posedge r_Clk);
    #1;
    r_Rst = 1'b1;
    model_reset();
  endtask

  initial begin
    for (int i = 0; i < 256; i++) m_mem[i] = 32'd0;
    model_reset();
    test_reset();
    test_fetch();
    test_load();
    test_store();
    test_alu_ops();
    test_random_alu();
    test_immediates();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
